// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor on the free-running reference clock: pulses the PLL reset, qualifies lock, retries on timeout.
// Define PLL_LOCK_LOSS_COUNT_EN to build the saturating lock-loss counter; otherwise loss_count is tied to zero.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       retry_req,
  output logic       pll_rst,
  output logic       user_reset,
  output logic       ready,
  output logic       fail,
  output logic [7:0] loss_count
);

  localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int CNT_W     = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);
  localparam int RETRY_W   = ($clog2(MAX_RETRY) < 1) ? 1 : $clog2(MAX_RETRY);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [RETRY_W-1:0]       retry_q, retry_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     locked_s;
  logic                     pll_rst_q, user_reset_q, ready_q, fail_q;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Output bits {pll_rst, user_reset, ready, fail} for a state.
  function automatic logic [3:0] decode(input state_t s);
    case (s)
      S_WAIT_LOCK: decode = 4'b0100;
      S_STABLE:    decode = 4'b0100;
      S_RUN:       decode = 4'b0010;
      S_FAIL:      decode = 4'b0101;
      default:     decode = 4'b1100;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          cnt_d = '0;
          if (retry_q == RETRY_W'(MAX_RETRY - 1)) begin
            state_d = S_FAIL;
          end else begin
            state_d = S_PLL_RST;
            retry_d = retry_q + RETRY_W'(1);
          end
        end
      end
      S_STABLE: begin
        // A dropout here is treated as a glitch: restart the lock window without spending a retry.
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!locked_s) state_d = S_PLL_RST;
      end
      S_FAIL: begin
        cnt_d = '0;
        if (retry_req) begin
          state_d = S_PLL_RST;
          retry_d = '0;
        end
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they move on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q      <= S_PLL_RST;
      cnt_q        <= '0;
      retry_q      <= '0;
      sync_q       <= '0;
      pll_rst_q    <= 1'b1;
      user_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], locked};
      {pll_rst_q, user_reset_q, ready_q, fail_q} <= decode(state_d);
    end
  end

  assign pll_rst    = pll_rst_q;
  assign user_reset = user_reset_q;
  assign ready      = ready_q;
  assign fail       = fail_q;

`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic       loss_inc;
  logic [7:0] loss_q;

  assign loss_inc = (state_q == S_RUN) && !locked_s;

  always_ff @(posedge refclk) begin
    if (rst) begin
      loss_q <= 8'd0;
    end else if (loss_inc && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign loss_count = loss_q;
`else
  assign loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: a cycle model queues expected outputs, sampled 1 ns after each edge.
module tb_pll_lock_supervisor;

  localparam int RST_C  = 4;
  localparam int TO_C   = 20;
  localparam int STB_C  = 8;
  localparam int MR_C   = 2;

`ifdef PLL_LOCK_LOSS_COUNT_EN
  localparam int LOSS_EN = 1;
`else
  localparam int LOSS_EN = 0;
`endif

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       retry_req = 1'b0;
  logic       pll_rst, user_reset, ready, fail;
  logic [7:0] loss_count;

  pll_lock_supervisor #(
    .RST_CYCLES(RST_C), .LOCK_TIMEOUT(TO_C), .STABLE_CYCLES(STB_C),
    .MAX_RETRY(MR_C), .SYNC_STAGES(2)
  ) dut (
    .refclk(refclk), .rst(rst), .locked(locked), .retry_req(retry_req),
    .pll_rst(pll_rst), .user_reset(user_reset), .ready(ready), .fail(fail),
    .loss_count(loss_count)
  );

  always #5 refclk = ~refclk;

  int n_chk = 0;
  int n_pass = 0;
  logic [11:0] exp_q[$];
  logic saw_prst;

  // Reference model: 0=PLL_RST 1=WAIT_LOCK 2=STABLE 3=RUN 4=FAIL
  int   m_st, m_cnt, m_retry, m_loss;
  logic m_s1, m_s2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic model_step();
    logic ls;
    ls = m_s2;
    if (rst) begin
      m_st = 0; m_cnt = 0; m_retry = 0; m_loss = 0; m_s1 = 1'b0; m_s2 = 1'b0;
    end else begin
      case (m_st)
        0: if (m_cnt == RST_C - 1) begin m_st = 1; m_cnt = 0; end else m_cnt++;
        1: if (ls) begin m_st = 2; m_cnt = 0; end
           else if (m_cnt == TO_C - 1) begin
             m_cnt = 0;
             if (m_retry == MR_C - 1) m_st = 4;
             else begin m_retry++; m_st = 0; end
           end else m_cnt++;
        2: if (!ls) begin m_st = 1; m_cnt = 0; end
           else if (m_cnt == STB_C - 1) begin m_st = 3; m_cnt = 0; m_retry = 0; end
           else m_cnt++;
        3: if (!ls) begin
             m_st = 0; m_cnt = 0;
             if (LOSS_EN != 0 && m_loss < 255) m_loss++;
           end
        default: if (retry_req) begin m_st = 0; m_cnt = 0; m_retry = 0; end
      endcase
      m_s2 = m_s1;
      m_s1 = locked;
    end
    exp_q.push_back({(m_st == 0), (m_st != 3), (m_st == 3), (m_st == 4), 8'(m_loss)});
  endtask

  task automatic tick();
    logic [11:0] e;
    model_step();
    @(posedge refclk);
    #1;
    e = exp_q.pop_front();
    check("cycle_outputs", {20'd0, pll_rst, user_reset, ready, fail, loss_count}, {20'd0, e});
    if (pll_rst) saw_prst = 1'b1;
  endtask

  function automatic logic sigv(input int k);
    case (k)
      0:       sigv = pll_rst;
      1:       sigv = user_reset;
      2:       sigv = ready;
      default: sigv = fail;
    endcase
  endfunction

  // Ticks until output k equals v; n is the number of edges taken (== maxc on timeout).
  task automatic wait_sig(input int k, input logic v, input int maxc, output int n);
    n = 0;
    while (sigv(k) !== v && n < maxc) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int bad;

    // Reset state
    repeat (3) tick();
    check("reset_outputs", {20'd0, pll_rst, user_reset, ready, fail, loss_count}, 32'hC00);

    // 1: normal bring-up
    rst = 1'b0;
    wait_sig(0, 1'b0, 10, n);
    check("t1_pll_rst_width", n, RST_C);
    repeat (5) tick();
    locked = 1'b1;
    wait_sig(2, 1'b1, 40, n);
    check("t1_ready_latency", n, 11);
    check("t1_user_reset", user_reset, 1'b0);
    check("t1_fail", fail, 1'b0);

    // 4: loss in RUN
    locked = 1'b0;
    wait_sig(2, 1'b0, 10, n);
    check("t4_drop_latency", n, 3);
    check("t4_user_reset", user_reset, 1'b1);
    check("t4_loss_count", loss_count, LOSS_EN);
    check("t4_pll_rst_high", pll_rst, 1'b1);
    wait_sig(0, 1'b0, 10, n);
    check("t4_pll_rst_width", n, RST_C);

    // 2: glitch during STABLE
    saw_prst = 1'b0;
    locked = 1'b1;
    repeat (5) tick();
    locked = 1'b0;
    repeat (3) tick();
    locked = 1'b1;
    wait_sig(2, 1'b1, 40, n);
    check("t2_ready_latency", n, 11);
    check("t2_no_pll_rst", saw_prst, 1'b0);

    // 3: lock never arrives
    rst = 1'b1;
    locked = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    wait_sig(0, 1'b0, 10, n);
    check("t3_pulse1_width", n, RST_C);
    wait_sig(0, 1'b1, 40, n);
    check("t3_timeout1", n, TO_C);
    wait_sig(0, 1'b0, 10, n);
    check("t3_pulse2_width", n, RST_C);
    wait_sig(3, 1'b1, 40, n);
    check("t3_fail_latency", n, TO_C);
    check("t3_user_reset", user_reset, 1'b1);
    repeat (5) tick();
    check("t3_fail_held", fail, 1'b1);

    // 5: recovery from FAIL
    retry_req = 1'b1;
    tick();
    retry_req = 1'b0;
    check("t5_fail_low", fail, 1'b0);
    check("t5_pll_rst", pll_rst, 1'b1);
    locked = 1'b1;
    wait_sig(2, 1'b1, 60, n);
    check("t5_bringup_done", (n < 60), 1'b1);
    retry_req = 1'b1;
    tick();
    retry_req = 1'b0;
    tick();
    check("t5_retry_in_run", {ready, pll_rst, fail}, 3'b100);

    // 6: saturation and reset
    bad = 0;
    for (int i = 0; i < 260; i++) begin
      locked = 1'b0;
      wait_sig(2, 1'b0, 10, n);
      if (n == 10) bad++;
      wait_sig(0, 1'b0, 10, n);
      if (n == 10) bad++;
      locked = 1'b1;
      wait_sig(2, 1'b1, 40, n);
      if (n == 40) bad++;
    end
    check("t6_loop_timeouts", bad, 0);
    check("t6_saturated", loss_count, (LOSS_EN != 0) ? 255 : 0);
    rst = 1'b1;
    tick();
    check("t6_after_rst", {20'd0, pll_rst, user_reset, ready, fail, loss_count}, 32'hC00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
